// File: rtl/mips_pkg.sv
//==============================================================================
// Module      : mips_pkg
// Description : Shared MIPS constants: datapath width, opcode/funct codes,
//               the NOP encoding and instruction field bit positions.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mips_pkg;

    localparam int DATA_W = 32;

    // Opcodes
    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] SW     = 6'h2B;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] J      = 6'h02;

    // R-type funct codes
    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_ADD = 6'h20;

    // sll $0,$0,0 - the pipeline bubble
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Field bit positions
    localparam int OPCODE_MSB  = 31;
    localparam int OPCODE_LSB  = 26;
    localparam int RS_MSB      = 25;
    localparam int RS_LSB      = 21;
    localparam int RT_MSB      = 20;
    localparam int RT_LSB      = 16;
    localparam int RD_MSB      = 15;
    localparam int RD_LSB      = 11;
    localparam int SHAMT_MSB   = 10;
    localparam int SHAMT_LSB   = 6;
    localparam int FUNCT_MSB   = 5;
    localparam int FUNCT_LSB   = 0;
    localparam int IMM_MSB     = 15;
    localparam int IMM_LSB     = 0;
    localparam int JTARGET_MSB = 25;
    localparam int JTARGET_LSB = 0;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/instr_field_split.sv
//==============================================================================
// Module      : instr_field_split
// Description : Purely combinational slicing of a MIPS instruction word into
//               its decode fields; reusable by any pipeline stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_field_split
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jtarget
);

    assign opcode  = instr[OPCODE_MSB:OPCODE_LSB];
    assign rs      = instr[RS_MSB:RS_LSB];
    assign rt      = instr[RT_MSB:RT_LSB];
    assign rd      = instr[RD_MSB:RD_LSB];
    assign shamt   = instr[SHAMT_MSB:SHAMT_LSB];
    assign funct   = instr[FUNCT_MSB:FUNCT_LSB];
    assign imm16   = instr[IMM_MSB:IMM_LSB];
    assign jtarget = instr[JTARGET_MSB:JTARGET_LSB];

endmodule : instr_field_split

`default_nettype wire

// File: rtl/if_id_register.sv
//==============================================================================
// Module      : if_id_register
// Description : IF/ID pipeline register with stall hold, flush-to-bubble and
//               a saturating stall counter; presents decoded fields.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module if_id_register
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [DATA_W-1:0] pc_plus4_in,
    output logic [DATA_W-1:0] instr_out,
    output logic [DATA_W-1:0] pc_plus4_out,
    output logic              valid_out,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       imm16,
    output logic [25:0]       jtarget,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_pc_plus4;
    logic              r_valid;
    logic [CNT_W-1:0]  r_stall_count;

    // Priority rst > flush > stall > load; flush never counts as a stall cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr       <= '0;
            r_pc_plus4    <= '0;
            r_valid       <= 1'b0;
            r_stall_count <= '0;
        end else if (flush) begin
            r_instr    <= DATA_W'(NOP_INSTR);
            r_pc_plus4 <= pc_plus4_in;
            r_valid    <= 1'b0;
        end else if (stall) begin
            if (r_stall_count != c_cnt_max) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end else begin
            r_instr    <= instr_in;
            r_pc_plus4 <= pc_plus4_in;
            r_valid    <= 1'b1;
        end
    end

    assign instr_out    = r_instr;
    assign pc_plus4_out = r_pc_plus4;
    assign valid_out    = r_valid;
    assign stall_count  = r_stall_count;

    // Fields come from the registered word only, so no input reaches them combinationally
    instr_field_split u_field_split (
        .instr   (r_instr[31:0]),
        .opcode  (opcode),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .funct   (funct),
        .imm16   (imm16),
        .jtarget (jtarget)
    );

endmodule : if_id_register

`default_nettype wire

// File: tb/tb_if_id_register.sv
//==============================================================================
// Module      : tb_if_id_register
// Description : Directed self-checking bench for if_id_register (CNT_W=8 and
//               a CNT_W=4 instance sharing the same stimulus).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_if_id_register;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] instr_in;
    logic [31:0] pc_plus4_in;

    logic [31:0] instr_out, pc_plus4_out;
    logic        valid_out;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] jtarget;
    logic [7:0]  stall_count;

    logic [31:0] t4_instr_out, t4_pc_plus4_out;
    logic        t4_valid_out;
    logic [5:0]  t4_opcode, t4_funct;
    logic [4:0]  t4_rs, t4_rt, t4_rd, t4_shamt;
    logic [15:0] t4_imm16;
    logic [25:0] t4_jtarget;
    logic [3:0]  t4_stall_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_id_register #(.DATA_W(32), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .instr_in(instr_in), .pc_plus4_in(pc_plus4_in),
        .instr_out(instr_out), .pc_plus4_out(pc_plus4_out), .valid_out(valid_out),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm16(imm16), .jtarget(jtarget), .stall_count(stall_count)
    );

    if_id_register #(.DATA_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .instr_in(instr_in), .pc_plus4_in(pc_plus4_in),
        .instr_out(t4_instr_out), .pc_plus4_out(t4_pc_plus4_out), .valid_out(t4_valid_out),
        .opcode(t4_opcode), .rs(t4_rs), .rt(t4_rt), .rd(t4_rd), .shamt(t4_shamt),
        .funct(t4_funct), .imm16(t4_imm16), .jtarget(t4_jtarget),
        .stall_count(t4_stall_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with garbage on the instruction bus
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        instr_in = 32'hFFFF_FFFF; pc_plus4_in = 32'h1234_5678;
        tick(); tick();
        check("rst_instr", instr_out, 32'h0);
        check("rst_pc", pc_plus4_out, 32'h0);
        check("rst_valid", {31'b0, valid_out}, 32'h0);
        check("rst_cnt", {24'b0, stall_count}, 32'h0);
        check("rst_cnt4", {28'b0, t4_stall_count}, 32'h0);
        check("rst_opcode", {26'b0, opcode}, 32'h0);

        // Load addi $t1,$t0,-4
        rst = 1'b0; instr_in = 32'h2109_FFFC; pc_plus4_in = 32'h0040_0004;
        tick();
        check("ld_instr", instr_out, 32'h2109_FFFC);
        check("ld_opcode", {26'b0, opcode}, 32'h08);
        check("ld_rs", {27'b0, rs}, 32'd8);
        check("ld_rt", {27'b0, rt}, 32'd9);
        check("ld_rd", {27'b0, rd}, 32'd31);
        check("ld_shamt", {27'b0, shamt}, 32'd31);
        check("ld_funct", {26'b0, funct}, 32'h3C);
        check("ld_imm16", {16'b0, imm16}, 32'hFFFC);
        check("ld_jtarget", {6'b0, jtarget}, 32'h0109_FFFC);
        check("ld_pc", pc_plus4_out, 32'h0040_0004);
        check("ld_valid", {31'b0, valid_out}, 32'h1);

        // Three stall cycles; the middle one carries X on the instruction bus
        stall = 1'b1; instr_in = 32'h8D28_0004; pc_plus4_in = 32'h0040_0008;
        tick();
        check("st1_instr", instr_out, 32'h2109_FFFC);
        check("st1_cnt", {24'b0, stall_count}, 32'd1);
        instr_in = 'x;
        tick();
        check("st2_instr", instr_out, 32'h2109_FFFC);
        check("st2_opcode", {26'b0, opcode}, 32'h08);
        instr_in = 32'h8D28_0004;
        tick();
        check("st3_instr", instr_out, 32'h2109_FFFC);
        check("st3_pc", pc_plus4_out, 32'h0040_0004);
        check("st3_valid", {31'b0, valid_out}, 32'h1);
        check("st3_cnt", {24'b0, stall_count}, 32'd3);
        check("st3_cnt4", {28'b0, t4_stall_count}, 32'd3);

        // Release: lw $t0,4($t1)
        stall = 1'b0;
        tick();
        check("rel_instr", instr_out, 32'h8D28_0004);
        check("rel_opcode", {26'b0, opcode}, 32'h23);
        check("rel_rs", {27'b0, rs}, 32'd9);
        check("rel_rt", {27'b0, rt}, 32'd8);
        check("rel_imm16", {16'b0, imm16}, 32'h0004);
        check("rel_pc", pc_plus4_out, 32'h0040_0008);
        check("rel_cnt", {24'b0, stall_count}, 32'd3);

        // Flush with simultaneous stall; flush wins, counter frozen
        stall = 1'b1; flush = 1'b1; instr_in = 'x; pc_plus4_in = 32'h0040_0010;
        tick();
        check("fl_instr", instr_out, 32'h0);
        check("fl_valid", {31'b0, valid_out}, 32'h0);
        check("fl_pc", pc_plus4_out, 32'h0040_0010);
        check("fl_cnt", {24'b0, stall_count}, 32'd3);
        check("fl_funct", {26'b0, funct}, 32'h0);

        // Back-to-back flush
        stall = 1'b0; pc_plus4_in = 32'h0040_0014;
        tick();
        check("fl2_instr", instr_out, 32'h0);
        check("fl2_valid", {31'b0, valid_out}, 32'h0);
        check("fl2_pc", pc_plus4_out, 32'h0040_0014);

        // Long stall: 4-bit counter saturates at 15, 8-bit reaches 23
        flush = 1'b0; stall = 1'b1; instr_in = 32'hDEAD_BEEF;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 12) check("sat_cnt4_reach", {28'b0, t4_stall_count}, 32'd15);
        end
        check("sat_cnt4_hold", {28'b0, t4_stall_count}, 32'd15);
        check("sat_cnt8", {24'b0, stall_count}, 32'd23);
        check("sat_instr", instr_out, 32'h0);
        check("sat_pc", pc_plus4_out, 32'h0040_0014);

        // Reset pulse in the middle of the stall
        rst = 1'b1;
        tick();
        check("rms_cnt", {24'b0, stall_count}, 32'd0);
        check("rms_cnt4", {28'b0, t4_stall_count}, 32'd0);
        check("rms_pc", pc_plus4_out, 32'h0);
        check("rms_valid", {31'b0, valid_out}, 32'h0);

        // Normal loading resumes: sw $t2,8($0)
        rst = 1'b0; stall = 1'b0; instr_in = 32'hAC0A_0008; pc_plus4_in = 32'h0040_0020;
        tick();
        check("post_instr", instr_out, 32'hAC0A_0008);
        check("post_opcode", {26'b0, opcode}, 32'h2B);
        check("post_rt", {27'b0, rt}, 32'd10);
        check("post_valid", {31'b0, valid_out}, 32'h1);

        // R-type: add $t0,$t1,$t2
        instr_in = 32'h012A_4020; pc_plus4_in = 32'h0040_0024;
        tick();
        check("r_rs", {27'b0, rs}, 32'd9);
        check("r_rt", {27'b0, rt}, 32'd10);
        check("r_rd", {27'b0, rd}, 32'd8);
        check("r_shamt", {27'b0, shamt}, 32'd0);
        check("r_funct", {26'b0, funct}, 32'h20);
        check("r_pc", pc_plus4_out, 32'h0040_0024);
        check("r_cnt", {24'b0, stall_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_if_id_register

`default_nettype wire
